// File: rtl/race_finish_tracker.sv
// Tracks each player's arrival at the finish cell, with competition ranks, the win pulse and the post-win hold timer.
// Optional build macro: RACE_FINISH_ALL_EN (hold_done also waits until every player has finished).
module race_finish_tracker #(
  parameter int MAX_POS     = 109,
  parameter int PLAYERS     = 4,
  parameter int HOLD_CYCLES = 50000000,
  localparam int PW = $clog2(MAX_POS),
  localparam int RW = $clog2(PLAYERS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_in_menu,
  input  logic [PLAYERS*PW-1:0] pos_bus,
  output logic                  result,
  output logic                  win_pulse,
  output logic [PLAYERS-1:0]    winner_mask,
  output logic                  tie,
  output logic [PLAYERS-1:0]    finished_mask,
  output logic [RW-1:0]         finish_count,
  output logic [PLAYERS*RW-1:0] rank_bus,
  output logic                  hold_done
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {MENU, RACING, WON, DONE} state_t;

  state_t             state_reg;
  logic [PLAYERS-1:0] hit;
  logic [PLAYERS-1:0] finished_mask_reg;
  logic [PLAYERS-1:0] winner_mask_reg;
  logic [RW-1:0]      rank_reg [PLAYERS];
  logic [RW-1:0]      hit_count;
  logic [RW-1:0]      finish_count_reg;
  logic [RW-1:0]      cur_rank;
  logic [CW-1:0]      hold_cnt_reg;
  logic               result_reg;
  logic               win_pulse_reg;
  logic               tie_reg;
  logic               hold_done_reg;
  logic               hold_expired;

  // Positions beyond the finish cell never match, so they are ignored.
  generate
    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player
      assign hit[gi] = (pos_bus[gi*PW +: PW] == PW'(MAX_POS - 1)) && !finished_mask_reg[gi];
      assign rank_bus[gi*RW +: RW] = rank_reg[gi];
    end
  endgenerate

  always_comb begin
    hit_count = '0;
    for (int i = 0; i < PLAYERS; i++) begin
      hit_count = hit_count + RW'(hit[i]);
    end
  end

  // Simultaneous finishers all take the rank following everyone already home.
  assign cur_rank = finish_count_reg + RW'(1);

`ifdef RACE_FINISH_ALL_EN
  assign hold_expired = (hold_cnt_reg == '0) && (&(finished_mask_reg | hit));
`else
  assign hold_expired = (hold_cnt_reg == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst || is_in_menu) begin
      state_reg         <= MENU;
      finished_mask_reg <= '0;
      winner_mask_reg   <= '0;
      finish_count_reg  <= '0;
      hold_cnt_reg      <= '0;
      result_reg        <= 1'b0;
      win_pulse_reg     <= 1'b0;
      tie_reg           <= 1'b0;
      hold_done_reg     <= 1'b0;
      for (int i = 0; i < PLAYERS; i++) begin
        rank_reg[i] <= '0;
      end
    end else begin
      win_pulse_reg     <= 1'b0;
      finished_mask_reg <= finished_mask_reg | hit;
      finish_count_reg  <= finish_count_reg + hit_count;
      for (int i = 0; i < PLAYERS; i++) begin
        if (hit[i]) begin
          rank_reg[i] <= cur_rank;
        end
      end
      case (state_reg)
        MENU, RACING: begin
          if (|hit) begin
            state_reg       <= WON;
            result_reg      <= 1'b1;
            win_pulse_reg   <= 1'b1;
            winner_mask_reg <= hit;
            tie_reg         <= (hit_count > RW'(1));
            hold_cnt_reg    <= CW'(HOLD_CYCLES - 1);
          end else begin
            state_reg <= RACING;
          end
        end
        WON: begin
          if (hold_expired) begin
            hold_done_reg <= 1'b1;
            state_reg     <= DONE;
          end else if (hold_cnt_reg != '0) begin
            hold_cnt_reg <= hold_cnt_reg - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result        = result_reg;
  assign win_pulse     = win_pulse_reg;
  assign winner_mask   = winner_mask_reg;
  assign tie           = tie_reg;
  assign finished_mask = finished_mask_reg;
  assign finish_count  = finish_count_reg;
  assign hold_done     = hold_done_reg;

endmodule

// File: tb/tb_race_finish_tracker.sv
// Directed plus randomized bench for race_finish_tracker against an event-level race model.
module tb_race_finish_tracker;
  localparam int P  = 4;
  localparam int MP = 109;
  localparam int H  = 4;
  localparam int PW = $clog2(MP);
  localparam int RW = $clog2(P + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              is_in_menu;
  logic [P*PW-1:0]   pos_bus;
  logic              result;
  logic              win_pulse;
  logic [P-1:0]      winner_mask;
  logic              tie;
  logic [P-1:0]      finished_mask;
  logic [RW-1:0]     finish_count;
  logic [P*RW-1:0]   rank_bus;
  logic              hold_done;

  race_finish_tracker #(.MAX_POS(MP), .PLAYERS(P), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .is_in_menu(is_in_menu), .pos_bus(pos_bus),
    .result(result), .win_pulse(win_pulse), .winner_mask(winner_mask), .tie(tie),
    .finished_mask(finished_mask), .finish_count(finish_count), .rank_bus(rank_bus),
    .hold_done(hold_done)
  );

  int vectors = 0;
  int miscompares = 0;
  int pos_v[P];

  // Race model: who is home, their ranks, and edges elapsed since the winning edge.
  logic [P-1:0] m_fin;
  int           m_rank[P];
  int           m_count;
  bit           m_won, m_done, m_pulse, m_tie;
  logic [P-1:0] m_wm;
  int           m_since;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [P-1:0] h;
    int nh;
    h = '0;
    nh = 0;
    if (rst || is_in_menu) begin
      m_fin = '0; m_count = 0; m_won = 0; m_done = 0; m_pulse = 0;
      m_tie = 0; m_wm = '0; m_since = 0;
      for (int i = 0; i < P; i++) m_rank[i] = 0;
    end else begin
      for (int i = 0; i < P; i++)
        if (pos_v[i] == MP - 1 && !m_fin[i]) begin h[i] = 1'b1; nh++; end
      for (int i = 0; i < P; i++)
        if (h[i]) begin m_rank[i] = m_count + 1; m_fin[i] = 1'b1; end
      m_count += nh;
      m_pulse = 0;
      if (!m_won) begin
        if (nh > 0) begin
          m_won = 1; m_pulse = 1; m_wm = h; m_tie = (nh > 1); m_since = 0;
        end
      end else if (!m_done) begin
        m_since++;
`ifdef RACE_FINISH_ALL_EN
        if (m_since >= H && m_fin == '1) m_done = 1;
`else
        if (m_since >= H) m_done = 1;
`endif
      end
    end
  endtask

  task automatic compare_all();
    logic [P*RW-1:0] e_rank;
    for (int i = 0; i < P; i++) e_rank[i*RW +: RW] = RW'(m_rank[i]);
    check("result", 64'(result), 64'(m_won));
    check("win_pulse", 64'(win_pulse), 64'(m_pulse));
    check("winner_mask", 64'(winner_mask), 64'(m_wm));
    check("tie", 64'(tie), 64'(m_tie));
    check("finished_mask", 64'(finished_mask), 64'(m_fin));
    check("finish_count", 64'(finish_count), 64'(m_count));
    check("rank_bus", 64'(rank_bus), 64'(e_rank));
    check("hold_done", 64'(hold_done), 64'(m_done));
  endtask

  task automatic step();
    for (int i = 0; i < P; i++) pos_bus[i*PW +: PW] = PW'(pos_v[i]);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < P; i++) pos_v[i] = v;
  endtask

  initial begin
    rst = 1'b1; is_in_menu = 1'b1; set_all(0);
    step(); step();
    check("rst_result", 64'(result), 64'd0);
    check("rst_hold_done", 64'(hold_done), 64'd0);
    rst = 1'b0;
    step();

    // Idle race: nobody moves.
    is_in_menu = 1'b0;
    repeat (10) step();
    check("idle_result", 64'(result), 64'd0);
    check("idle_count", 64'(finish_count), 64'd0);

    // Single winner and hold timer.
    pos_v[2] = MP - 1;
    step();
    check("p2_wm", 64'(winner_mask), 64'h4);
    check("p2_pulse", 64'(win_pulse), 64'd1);
    check("p2_rank", 64'(rank_bus[2*RW +: RW]), 64'd1);
    step();
    check("p2_pulse_once", 64'(win_pulse), 64'd0);
    step(); step();
    check("p2_hold_early", 64'(hold_done), 64'd0);
    step();
    check("p2_hold_done", 64'(hold_done), 64'd1);

    // Tie for first, later third place.
    is_in_menu = 1'b1; set_all(0); step();
    is_in_menu = 1'b0; step();
    pos_v[0] = MP - 1; pos_v[3] = MP - 1; pos_v[1] = 50; step();
    check("tie_wm", 64'(winner_mask), 64'h9);
    check("tie_flag", 64'(tie), 64'd1);
    step();
    pos_v[1] = MP - 1; step();
    check("third_rank", 64'(rank_bus[1*RW +: RW]), 64'd3);
    check("third_count", 64'(finish_count), 64'd3);
    check("third_wm", 64'(winner_mask), 64'h9);

    // Sticky finish and out-of-range position.
    is_in_menu = 1'b1; set_all(0); step();
    is_in_menu = 1'b0; pos_v[1] = MP - 1; pos_v[0] = 120; step(); step();
    pos_v[1] = 50; step(); step();
    check("sticky_mask1", 64'(finished_mask[1]), 64'd1);
    check("sticky_rank1", 64'(rank_bus[1*RW +: RW]), 64'd1);
    check("oor_mask0", 64'(finished_mask[0]), 64'd0);

    // Menu mid-hold, then fresh race; reset mid-race.
    is_in_menu = 1'b1; set_all(0); step();
    is_in_menu = 1'b0; pos_v[3] = MP - 1; step(); step();
    is_in_menu = 1'b1; step();
    check("menu_clear_result", 64'(result), 64'd0);
    is_in_menu = 1'b0; step();
    check("rerace_pulse", 64'(win_pulse), 64'd1);
    rst = 1'b1; step();
    check("rst_mid_result", 64'(result), 64'd0);
    rst = 1'b0; step();
    check("post_rst_pulse", 64'(win_pulse), 64'd1);

    // Randomized races against the model.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      is_in_menu = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < P; i++) begin
        case ($urandom_range(0, 11))
          0, 1:    pos_v[i] = MP - 1;
          2:       pos_v[i] = $urandom_range(MP, (1 << PW) - 1);
          default: pos_v[i] = $urandom_range(0, MP - 2);
        endcase
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
